fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/HOLD sequencer that requests a word, holds it for the consumer and advances the PC.
// Optional macro FETCH_MISALIGN_CHK_EN: misaligned redirect targets raise sticky Fault and halt instead of being aligned.
module fetch_unit #(
  parameter logic [63:0] ResetPC = 64'h0
) (
  input  logic        CLK,
  input  logic        ResetL,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] InstrOut,
  output logic [1:0]  ExtCtrl,
  output logic [63:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [63:0] BusImm,
  output logic        Fault
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic [1:0] HALT  = 2'd3;
`endif

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic [1:0]      ext_q, ext_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] tgt_br, tgt_seq;
`ifdef FETCH_MISALIGN_CHK_EN
  logic            fault_q, fault_d;
`endif

  // Sign-extender control for an instruction word; registered alongside the word itself.
  function automatic logic [1:0] ext_decode(input logic [ILEN-1:0] w);
    logic [1:0] r;
    r = 2'b01;
    if (w[31:26] == 6'b000101) begin
      r = 2'b00;
    end else if (w[31:24] == 8'b10110100 || w[31:24] == 8'b10110101) begin
      r = 2'b11;
    end else if (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000) begin
      r = 2'b10;
    end
    return r;
  endfunction

  always_comb begin
    tgt_br  = ipc_q + BusImm;
    tgt_seq = ipc_q + XLEN'(4);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ext_d   = ext_q;
`ifdef FETCH_MISALIGN_CHK_EN
    fault_d = fault_q;
`endif
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (IMemAck) begin
          instr_d = IMemData;
          ipc_d   = pc_q;
          ext_d   = ext_decode(IMemData);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (InstrReady) begin
`ifdef FETCH_MISALIGN_CHK_EN
          if (Redirect && (tgt_br[1:0] != 2'b00)) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = Redirect ? tgt_br : tgt_seq;
            state_d = FETCH;
          end
`else
          pc_d    = Redirect ? {tgt_br[XLEN-1:2], 2'b00} : tgt_seq;
          state_d = FETCH;
`endif
        end
      end
`ifdef FETCH_MISALIGN_CHK_EN
      HALT: state_d = HALT;
`endif
      default: state_d = IDLE;
    endcase
    req_d   = (state_d == FETCH);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge CLK or negedge ResetL) begin
    if (!ResetL) begin
      state_q <= IDLE;
      pc_q    <= ResetPC;
      instr_q <= '0;
      ipc_q   <= '0;
      ext_q   <= 2'b01;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ext_q   <= ext_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge CLK or negedge ResetL) begin
    if (!ResetL) fault_q <= 1'b0;
    else         fault_q <= fault_d;
  end
  assign Fault = fault_q;
`else
  assign Fault = 1'b0;
`endif

  assign IMemReq    = req_q;
  assign IMemAddr   = pc_q;
  assign InstrOut   = instr_q;
  assign InstrPC    = ipc_q;
  assign ExtCtrl    = ext_q;
  assign InstrValid = valid_q;

endmodule
